// File: rtl/atmr_campaign_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : atmr_campaign_pkg
//  Description : Shared types and constants for the ATMR fault campaign
//                controller: FSM state encoding, default vector/bus widths,
//                number of vectors in an exhaustive sweep, counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package atmr_campaign_pkg;

    localparam int N_IN_DEF  = 7;
    localparam int N_OUT_DEF = 10;
    localparam int NUM_VEC   = 2 ** N_IN_DEF;
    localparam int CNT_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_NEXT    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/atmr_err_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : atmr_err_cnt
//  Description : Saturating mismatch counter. i_clr wins over i_inc; the
//                count sticks at all-ones instead of wrapping.
//  Ports       : clk, rst_n (sync, active-low), i_clr, i_inc, o_cnt[CNT_W]
//  Revision    : 1.0  initial release
// ============================================================================
module atmr_err_cnt
    import atmr_campaign_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/atmr_campaign_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : atmr_campaign_ctrl
//  Description : Exhaustive stimulus sweep for an ATMR circuit. Each vector
//                is driven, allowed to settle, then the three replica buses
//                and the voted bus are compared to the golden outputs.
//  Ports       : clk, rst_n (sync, active-low), start, abort
//                dut_in[N_IN]             registered stimulus
//                ori_z/mai_z/men_z[N_OUT] replica outputs (pre-vote)
//                vote_z[N_OUT], gold_z[N_OUT]
//                busy, done
//                ori/mai/men/vote_err_cnt, mask_cnt [8]
//                first_fail_vec[N_IN], first_fail_vld
//  Revision    : 1.0  initial release
// ============================================================================
module atmr_campaign_ctrl
    import atmr_campaign_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int N_IN          = N_IN_DEF,
    parameter int N_OUT         = N_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] ori_z,
    input  logic [N_OUT-1:0] mai_z,
    input  logic [N_OUT-1:0] men_z,
    input  logic [N_OUT-1:0] vote_z,
    input  logic [N_OUT-1:0] gold_z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ori_err_cnt,
    output logic [CNT_W-1:0] mai_err_cnt,
    output logic [CNT_W-1:0] men_err_cnt,
    output logic [CNT_W-1:0] vote_err_cnt,
    output logic [CNT_W-1:0] mask_cnt,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_vld
);

    localparam int SW = 4;

    state_t          r_state;
    state_t          w_next;
    logic [N_IN-1:0] r_vec;
    logic [N_IN-1:0] r_dut_in;
    logic [N_IN-1:0] r_ff_vec;
    logic            r_ff_vld;
    logic            r_done;
    logic [SW-1:0]   r_settle;

    // start is only honoured in IDLE and only without a simultaneous abort
    logic w_start_ok;
    logic w_abort;
    logic w_capture;
    logic w_last;
    logic w_ori_mis, w_mai_mis, w_men_mis, w_vote_mis, w_mask;

    assign w_start_ok = (r_state == S_IDLE) && start && !abort;
    assign w_abort    = (r_state != S_IDLE) && abort;
    assign w_capture  = (r_state == S_CAPTURE) && !abort;
    assign w_last     = &r_vec;

    // Replica comparison: one count per vector regardless of how many bits differ
    assign w_ori_mis  = (ori_z  != gold_z);
    assign w_mai_mis  = (mai_z  != gold_z);
    assign w_men_mis  = (men_z  != gold_z);
    assign w_vote_mis = (vote_z != gold_z);
    assign w_mask     = (w_ori_mis || w_mai_mis || w_men_mis) && !w_vote_mis;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start_ok) w_next = S_APPLY;
            S_APPLY:   w_next = S_SETTLE;
            S_SETTLE:  if (r_settle == '0) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_NEXT;
            S_NEXT:    w_next = w_last ? S_IDLE : S_APPLY;
            default:   w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vec    <= '0;
            r_dut_in <= '0;
            r_ff_vec <= '0;
            r_ff_vld <= 1'b0;
            r_done   <= 1'b0;
            r_settle <= '0;
        end else if (w_start_ok) begin
            r_vec    <= '0;
            r_ff_vec <= '0;
            r_ff_vld <= 1'b0;
            r_done   <= 1'b0;
        end else if (!w_abort) begin
            case (r_state)
                S_APPLY: begin
                    r_dut_in <= r_vec;
                    r_settle <= SW'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (r_settle != '0) r_settle <= r_settle - 1'b1;
                end
                S_CAPTURE: begin
                    if (w_vote_mis && !r_ff_vld) begin
                        r_ff_vec <= r_vec;
                        r_ff_vld <= 1'b1;
                    end
                end
                S_NEXT: begin
                    // On the last vector dut_in is simply left where it is
                    if (w_last) r_done <= 1'b1;
                    else        r_vec  <= r_vec + 1'b1;
                end
                default: ;
            endcase
        end
    end

    atmr_err_cnt u_ori_cnt (.clk(clk), .rst_n(rst_n), .i_clr(w_start_ok),
                            .i_inc(w_capture && w_ori_mis),  .o_cnt(ori_err_cnt));
    atmr_err_cnt u_mai_cnt (.clk(clk), .rst_n(rst_n), .i_clr(w_start_ok),
                            .i_inc(w_capture && w_mai_mis),  .o_cnt(mai_err_cnt));
    atmr_err_cnt u_men_cnt (.clk(clk), .rst_n(rst_n), .i_clr(w_start_ok),
                            .i_inc(w_capture && w_men_mis),  .o_cnt(men_err_cnt));
    atmr_err_cnt u_vote_cnt(.clk(clk), .rst_n(rst_n), .i_clr(w_start_ok),
                            .i_inc(w_capture && w_vote_mis), .o_cnt(vote_err_cnt));
    atmr_err_cnt u_mask_cnt(.clk(clk), .rst_n(rst_n), .i_clr(w_start_ok),
                            .i_inc(w_capture && w_mask),     .o_cnt(mask_cnt));

    assign dut_in         = r_dut_in;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign first_fail_vec = r_ff_vec;
    assign first_fail_vld = r_ff_vld;

endmodule
`default_nettype wire

// File: tb/tb_atmr_campaign_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_atmr_campaign_ctrl
//  Description : Bench for atmr_campaign_ctrl. A behavioural ATMR circuit
//                (golden function, per-vector replica flip masks, bitwise
//                majority voter) answers dut_in. Expected counters come from
//                a table for directed fault patterns and from a per-vector
//                counting model for random patterns and early aborts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_atmr_campaign_ctrl;

    localparam int NI = 7;
    localparam int NO = 10;
    localparam int NV = 128;
    localparam int S0 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    logic [NO-1:0] ori_flip [NV];
    logic [NO-1:0] mai_flip [NV];
    logic [NO-1:0] men_flip [NV];

    function automatic logic [NO-1:0] gold_f(input logic [NI-1:0] x);
        return NO'(x * 7 + 3) ^ {x[2:0], x};
    endfunction

    function automatic logic [NO-1:0] maj(input logic [NO-1:0] a, b, c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ---- main DUT (SETTLE_CYCLES = 2) ----
    logic [NI-1:0] dut_in, ffv;
    logic [NO-1:0] gold, ori, mai, men, vote;
    logic          busy, done, ffvld;
    logic [7:0]    c_ori, c_mai, c_men, c_vote, c_mask;

    assign gold = gold_f(dut_in);
    assign ori  = gold ^ ori_flip[dut_in];
    assign mai  = gold ^ mai_flip[dut_in];
    assign men  = gold ^ men_flip[dut_in];
    assign vote = maj(ori, mai, men);

    atmr_campaign_ctrl #(.SETTLE_CYCLES(S0), .N_IN(NI), .N_OUT(NO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in), .ori_z(ori), .mai_z(mai), .men_z(men),
        .vote_z(vote), .gold_z(gold), .busy(busy), .done(done),
        .ori_err_cnt(c_ori), .mai_err_cnt(c_mai), .men_err_cnt(c_men),
        .vote_err_cnt(c_vote), .mask_cnt(c_mask),
        .first_fail_vec(ffv), .first_fail_vld(ffvld));

    // ---- second DUT (SETTLE_CYCLES = 1), fault-free circuit ----
    logic [NI-1:0] dut_in1, ffv1;
    logic [NO-1:0] gold1;
    logic          busy1, done1, ffvld1;
    logic [7:0]    d_ori, d_mai, d_men, d_vote, d_mask;

    assign gold1 = gold_f(dut_in1);

    atmr_campaign_ctrl #(.SETTLE_CYCLES(1), .N_IN(NI), .N_OUT(NO)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in1), .ori_z(gold1), .mai_z(gold1), .men_z(gold1),
        .vote_z(gold1), .gold_z(gold1), .busy(busy1), .done(done1),
        .ori_err_cnt(d_ori), .mai_err_cnt(d_mai), .men_err_cnt(d_men),
        .vote_err_cnt(d_vote), .mask_cnt(d_mask),
        .first_fail_vec(ffv1), .first_fail_vld(ffvld1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_faults();
        for (int v = 0; v < NV; v++) begin
            ori_flip[v] = '0;
            mai_flip[v] = '0;
            men_flip[v] = '0;
        end
    endtask

    task automatic setup_kind(input int kind);
        clear_faults();
        for (int v = 0; v < NV; v++) begin
            case (kind)
                1: ori_flip[v] = 10'h008;
                2: if (v == 5 || v == 9) begin
                       ori_flip[v] = 10'h001;
                       mai_flip[v] = 10'h001;
                   end
                3: if (v == NV - 1) men_flip[v] = 10'h3FF;
                4: if (v % 2 == 0) mai_flip[v] = 10'h200;
                5: begin
                       if ($urandom_range(0, 7) == 0) ori_flip[v] = NO'($urandom_range(1, 1023));
                       if ($urandom_range(0, 7) == 0) mai_flip[v] = NO'($urandom_range(1, 1023));
                       if ($urandom_range(0, 7) == 0) men_flip[v] = NO'($urandom_range(1, 1023));
                   end
                default: ;
            endcase
        end
    endtask

    // Counts what a campaign should report after the first nv vectors were
    // judged. The voted output is wrong exactly where some bit is flipped in
    // two or more replicas.
    task automatic model(input int nv, output int eo, output int ema, output int emn,
                         output int ev, output int emk, output int vld, output int fv);
        eo = 0; ema = 0; emn = 0; ev = 0; emk = 0; vld = 0; fv = 0;
        for (int v = 0; v < nv; v++) begin
            logic [NO-1:0] two;
            logic          any_rep;
            two     = (ori_flip[v] & mai_flip[v]) | (ori_flip[v] & men_flip[v]) |
                      (mai_flip[v] & men_flip[v]);
            any_rep = (ori_flip[v] != 0) || (mai_flip[v] != 0) || (men_flip[v] != 0);
            if (ori_flip[v] != 0) eo++;
            if (mai_flip[v] != 0) ema++;
            if (men_flip[v] != 0) emn++;
            if (two != 0) begin
                ev++;
                if (vld == 0) begin vld = 1; fv = v; end
            end else if (any_rep) begin
                emk++;
            end
        end
    endtask

    task automatic chk_counts(input string tag, input int eo, input int ema, input int emn,
                              input int ev, input int emk, input int vld, input int fv);
        chk({tag, ".ori"},  int'(c_ori),  eo);
        chk({tag, ".mai"},  int'(c_mai),  ema);
        chk({tag, ".men"},  int'(c_men),  emn);
        chk({tag, ".vote"}, int'(c_vote), ev);
        chk({tag, ".mask"}, int'(c_mask), emk);
        chk({tag, ".ffvld"}, int'(ffvld), vld);
        if (vld != 0) chk({tag, ".ffvec"}, int'(ffv), fv);
    endtask

    // Start a campaign and count the cycles busy stays high (bounded)
    task automatic run_full(output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 5000) begin
            cyc++;
            tick();
        end
    endtask

    // Vectors whose CAPTURE cycle lies strictly before cycle k after start
    function automatic int captured_before(input int k);
        int n = 0;
        for (int v = 0; v < NV; v++)
            if (v * (S0 + 3) + S0 + 1 < k) n++;
        return n;
    endfunction

    typedef struct {
        int kind;
        int e_ori, e_mai, e_men, e_vote, e_mask, e_vld, e_vec;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int cyc, c0, c1, k;
        int eo, ema, emn, ev, emk, vld, fv;

        tbl[0] = '{0,   0,  0, 0, 0,   0, 0, 0};
        tbl[1] = '{1, 128,  0, 0, 0, 128, 0, 0};
        tbl[2] = '{2,   2,  2, 0, 2,   0, 1, 5};
        tbl[3] = '{3,   0,  0, 1, 0,   1, 0, 0};
        tbl[4] = '{4,   0, 64, 0, 0,  64, 0, 0};

        clear_faults();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.dut_in", int'(dut_in), 0);
        chk_counts("rst", 0, 0, 0, 0, 0, 0, 0);
        chk("rst.ffvec", int'(ffv), 0);

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort.busy", int'(busy), 0);

        // directed fault patterns
        for (int i = 0; i < 5; i++) begin
            setup_kind(tbl[i].kind);
            run_full(cyc);
            chk($sformatf("tbl%0d.len", i), cyc, NV * (S0 + 3));
            chk($sformatf("tbl%0d.done", i), int'(done), 1);
            chk_counts($sformatf("tbl%0d", i), tbl[i].e_ori, tbl[i].e_mai, tbl[i].e_men,
                       tbl[i].e_vote, tbl[i].e_mask, tbl[i].e_vld, tbl[i].e_vec);
            repeat (3) tick();
            chk($sformatf("tbl%0d.done_hold", i), int'(done), 1);
            chk($sformatf("tbl%0d.dut_in_hold", i), int'(dut_in), NV - 1);
        end

        // random fault patterns against the counting model
        for (int r = 0; r < 3; r++) begin
            setup_kind(5);
            run_full(cyc);
            model(NV, eo, ema, emn, ev, emk, vld, fv);
            chk($sformatf("rnd%0d.len", r), cyc, NV * (S0 + 3));
            chk_counts($sformatf("rnd%0d", r), eo, ema, emn, ev, emk, vld, fv);
        end

        // abort at cycle 100 (APPLY) and at cycle 103 (CAPTURE of vector 20)
        foreach (tbl[i]) begin
            if (i >= 2) break;
            k = (i == 0) ? 100 : 103;
            setup_kind(5);
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (k) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            model(captured_before(k), eo, ema, emn, ev, emk, vld, fv);
            chk($sformatf("abort%0d.busy", k), int'(busy), 0);
            chk($sformatf("abort%0d.done", k), int'(done), 0);
            chk_counts($sformatf("abort%0d", k), eo, ema, emn, ev, emk, vld, fv);
            repeat (6) tick();
            chk_counts($sformatf("abort%0d.hold", k), eo, ema, emn, ev, emk, vld, fv);
        end

        // reset during vector 50, then a clean full campaign
        setup_kind(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50 * (S0 + 3) + 1) tick();
        model(50, eo, ema, emn, ev, emk, vld, fv);
        chk("pre_rst.ori", int'(c_ori), eo);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.dut_in", int'(dut_in), 0);
        chk("midrst.ffvec", int'(ffv), 0);
        chk_counts("midrst", 0, 0, 0, 0, 0, 0, 0);
        setup_kind(0);
        run_full(cyc);
        chk("postrst.len", cyc, NV * (S0 + 3));
        chk("postrst.done", int'(done), 1);
        chk_counts("postrst", 0, 0, 0, 0, 0, 0, 0);

        // start pulse at cycle 200 ignored; SETTLE_CYCLES=1 instance runs 512
        start = 1'b1;
        tick();
        c0 = 0;
        c1 = 0;
        k  = 0;
        while ((busy || busy1) && k < 5000) begin
            if (busy)  c0++;
            if (busy1) c1++;
            start = (k == 200);
            k++;
            tick();
        end
        start = 1'b0;
        chk("restart.len_s2", c0, NV * 5);
        chk("restart.len_s1", c1, NV * 4);
        chk("restart.done_s1", int'(done1), 1);
        chk("restart.vote_s1", int'(d_vote), 0);
        chk("restart.mask_s1", int'(d_mask) + int'(d_ori) + int'(d_mai) + int'(d_men), 0);
        chk("restart.ffvld_s1", int'(ffvld1), 0);
        chk("restart.ffvec_s1", int'(ffv1), 0);
        chk("restart.dut_in_s1", int'(dut_in1), NV - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
